// File: rtl/regfile_pkg.sv
`timescale 1ns/1ps
// Shared types and sizes for the 16 x 8-bit register bank (write side and read mux).
package regfile_pkg;

  localparam int NREG   = 16;
  localparam int RWIDTH = 8;
  localparam int AWIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  typedef logic [RWIDTH-1:0] rf_byte_t;
  typedef logic [AWIDTH-1:0] rf_addr_t;
  typedef logic [NREG-1:0]   rf_sel_t;

endpackage

// File: rtl/regfile_wr16_if.sv
`timescale 1ns/1ps
// Write-port bundle of the register bank: valid/ready byte writes, clear request,
// status outputs and the register contents consumed by the read mux.
interface regfile_wr16_if;
  import regfile_pkg::*;

  logic     wr_valid;
  logic     wr_ready;
  rf_addr_t wr_addr;
  rf_byte_t wr_data;
  logic     clr_req;
  logic     busy;
  logic     wr_done;
  rf_sel_t  wsel;
  rf_byte_t regq [NREG];

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output clr_req,
    input  wr_ready,
    input  busy,
    input  wr_done,
    input  wsel,
    input  regq
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  clr_req,
    output wr_ready,
    output busy,
    output wr_done,
    output wsel,
    output regq
  );

endinterface

// File: rtl/regfile_wr16_dec416.sv
`timescale 1ns/1ps
// 4-to-16 one-hot decoder. A nonzero gate delay selects the two-level
// predecoded NAND/NOR structure; zero selects a plain shift decode.
module dec416
  import regfile_pkg::*;
#(
  parameter realtime NAND_TIME = 7ns
) (
  input  rf_addr_t i_addr,
  output rf_sel_t  o_sel
);

  if (NAND_TIME > 0ns) begin : g_gate
    logic [3:0] w_lo;
    logic [3:0] w_hi;

    // Each 2-bit half is predecoded to four lines; one AND per output word-line.
    for (genvar gi = 0; gi < 4; gi++) begin : g_pre
      assign w_lo[gi] = (i_addr[1:0] == 2'(gi));
      assign w_hi[gi] = (i_addr[3:2] == 2'(gi));
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_line
      assign o_sel[gi] = w_hi[gi / 4] & w_lo[gi % 4];
    end
  end else begin : g_shift
    assign o_sel = rf_sel_t'(1) << i_addr;
  end

endmodule

// File: rtl/regfile_wr16.sv
`timescale 1ns/1ps
// Write side of the 16 x 8-bit register bank: handshaked byte writes, one-hot
// word-line decode, the register array itself and a 16-cycle clear sweep.
module regfile_wr16
  import regfile_pkg::*;
#(
  parameter realtime NAND_TIME = 7ns
) (
  input  logic           clk,
  input  logic           rst,
  regfile_wr16_if.slave  bus
);

  rf_state_t r_state;
  rf_state_t w_state_next;
  rf_addr_t  r_cnt;
  rf_sel_t   r_wsel;
  logic      r_wr_done;

  logic      w_wr_ready;
  logic      w_wr_en;
  logic      w_clr_en;
  logic      w_sweep_last;
  rf_addr_t  w_dec_addr;
  rf_sel_t   w_dec;

  assign w_sweep_last = (r_cnt == rf_addr_t'(NREG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.clr_req) w_state_next = CLEAR;
      CLEAR:   if (w_sweep_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // clr_req in IDLE blocks wr_ready, so a colliding write stays with its source.
  always_comb begin
    w_wr_ready = 1'b0;
    w_clr_en   = 1'b0;
    w_dec_addr = bus.wr_addr;
    unique case (r_state)
      IDLE: begin
        w_wr_ready = ~bus.clr_req;
      end
      CLEAR: begin
        w_clr_en   = 1'b1;
        w_dec_addr = r_cnt;
      end
      default: begin
        w_wr_ready = 1'b0;
      end
    endcase
  end

  assign w_wr_en = w_wr_ready & bus.wr_valid;

  dec416 #(
    .NAND_TIME (NAND_TIME)
  ) u_dec (
    .i_addr (w_dec_addr),
    .o_sel  (w_dec)
  );

  // Counter restarts on sweep entry and simply wraps to 0 after the last index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_clr_en) begin
      r_cnt <= r_cnt + rf_addr_t'(1);
    end else if (bus.clr_req) begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wsel    <= '0;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= w_wr_en;
      if (w_wr_en || w_clr_en) begin
        r_wsel <= w_dec;
      end
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    rf_byte_t r_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else if (w_dec[gi]) begin
        if (w_wr_en) begin
          r_q <= bus.wr_data;
        end else if (w_clr_en) begin
          r_q <= '0;
        end
      end
    end

    assign bus.regq[gi] = r_q;
  end

  assign bus.wr_ready = w_wr_ready;
  assign bus.busy     = (r_state == CLEAR);
  assign bus.wr_done  = r_wr_done;
  assign bus.wsel     = r_wsel;

endmodule

// File: tb/tb_regfile_wr16.sv
`timescale 1ns/1ps
// Bench for regfile_wr16: hand-built vector table, clear/collision/reset sequences,
// then randomized traffic checked against a register-array reference model.
module tb_regfile_wr16;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr16_if bus ();

  regfile_wr16 #(
    .NAND_TIME (7ns)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_reg [16];
  logic [15:0] m_wsel;
  bit          m_done;
  int          m_left;   // sweep edges still to come; 0 means idle

  typedef struct {
    bit        valid;
    bit [3:0]  addr;
    bit [7:0]  data;
    bit [7:0]  exp_q;
    bit        exp_done;
    bit [15:0] exp_wsel;
  } vec_t;

  vec_t vecs[$];

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
    m_wsel = 16'h0000;
    m_done = 1'b0;
    m_left = 0;
  endfunction

  // One rising edge of the specified behaviour, using the inputs held across it.
  function automatic void model_edge();
    if (m_left > 0) begin
      int k;
      k = 16 - m_left;
      m_reg[k] = 8'h00;
      m_wsel   = 16'h1 << k;
      m_done   = 1'b0;
      m_left--;
    end else if (bus.clr_req) begin
      m_left = 16;
      m_done = 1'b0;
    end else if (bus.wr_valid) begin
      m_reg[bus.wr_addr] = bus.wr_data;
      m_wsel = 16'h1 << bus.wr_addr;
      m_done = 1'b1;
    end else begin
      m_done = 1'b0;
    end
  endfunction

  task automatic check_all(string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s regq[%0d]", tag, i), bus.regq[i], m_reg[i]);
    chk({tag, " wsel"}, bus.wsel, m_wsel);
    chk({tag, " wr_done"}, bus.wr_done, m_done);
    chk({tag, " busy"}, bus.busy, m_left > 0);
    chk({tag, " wr_ready"}, bus.wr_ready, (m_left == 0) && !bus.clr_req);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_cnt;
    bit found;

    rst          = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.clr_req  = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset_async");
    @(negedge clk);
    rst = 1'b0;
    check_all("reset_release");
    $display("reset: regq/wsel/busy/wr_done cleared, wr_ready=%0b", bus.wr_ready);

    vecs.push_back('{1'b1, 4'd5, 8'hA7, 8'hA7, 1'b1, 16'h0020});
    vecs.push_back('{1'b0, 4'd5, 8'h00, 8'hA7, 1'b0, 16'h0020});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b1, 4'(i), 8'(8'h10 + i), 8'(8'h10 + i), 1'b1, 16'(16'h1 << i)});
    vecs.push_back('{1'b1, 4'd3, 8'h11, 8'h11, 1'b1, 16'h0008});
    vecs.push_back('{1'b1, 4'd3, 8'h22, 8'h22, 1'b1, 16'h0008});
    vecs.push_back('{1'b0, 4'd3, 8'h00, 8'h22, 1'b0, 16'h0008});

    foreach (vecs[v]) begin
      bus.wr_valid = vecs[v].valid;
      bus.wr_addr  = vecs[v].addr;
      bus.wr_data  = vecs[v].data;
      tick();
      chk($sformatf("vec%0d regq[%0d]", v, vecs[v].addr), bus.regq[vecs[v].addr], vecs[v].exp_q);
      chk($sformatf("vec%0d wr_done", v), bus.wr_done, vecs[v].exp_done);
      chk($sformatf("vec%0d wsel", v), bus.wsel, vecs[v].exp_wsel);
      check_all($sformatf("vec%0d", v));
      $display("vec%0d: valid=%0b addr=%0d data=%02h -> regq=%02h done=%0b wsel=%04h",
               v, vecs[v].valid, vecs[v].addr, vecs[v].data,
               bus.regq[vecs[v].addr], bus.wr_done, bus.wsel);
    end
    bus.wr_valid = 1'b0;

    // Clear sweep over a filled bank.
    bus.clr_req = 1'b1;
    #1 chk("clear wr_ready at request", bus.wr_ready, 0);
    tick();
    bus.clr_req = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus.busy) busy_cnt++;
      chk($sformatf("clear E%0d wr_ready", k), bus.wr_ready, 0);
      tick();
      chk($sformatf("clear regq[%0d] zeroed", k), bus.regq[k], 0);
      if (k < 15)
        chk($sformatf("clear regq[%0d] still set", k + 1), bus.regq[k + 1] != 8'h00, 1);
      check_all($sformatf("clear E%0d", k + 1));
    end
    chk("clear busy after E16", bus.busy, 0);
    chk("clear busy cycles", busy_cnt, 16);
    chk("clear wr_ready after E16", bus.wr_ready, 1);
    $display("clear: busy cycles=%0d", busy_cnt);

    // Clear request colliding with a write; source holds the write.
    bus.clr_req  = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd2;
    bus.wr_data  = 8'h55;
    tick();
    check_all("collision E0");
    bus.clr_req = 1'b0;
    n = 1;
    found = 1'b0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (bus.wr_done) found = 1'b1;
      else check_all($sformatf("collision E%0d", n - 1));
    end
    bus.wr_valid = 1'b0;
    chk("collision commit edge", n - 1, 17);
    chk("collision regq[2]", bus.regq[2], 8'h55);
    check_all("collision commit");
    $display("collision: write committed at E%0d regq[2]=%02h", n - 1, bus.regq[2]);

    // Reset in the middle of a sweep.
    bus.wr_addr = 4'd7;
    bus.wr_data = 8'h99;
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (7) tick();
    chk("midsweep busy before reset", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("midsweep reset");
    @(negedge clk);
    rst = 1'b0;
    check_all("midsweep release");
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd9;
    bus.wr_data  = 8'h3C;
    tick();
    bus.wr_valid = 1'b0;
    chk("post-reset regq[9]", bus.regq[9], 8'h3C);
    check_all("post-reset write");
    $display("reset mid-sweep: bank cleared, regq[9]=%02h", bus.regq[9]);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_addr  = 4'($urandom_range(0, 15));
      bus.wr_data  = 8'($urandom);
      bus.clr_req  = ($urandom_range(0, 39) == 0);
      tick();
      check_all($sformatf("rand%0d", c));
    end
    bus.wr_valid = 1'b0;
    bus.clr_req  = 1'b0;
    $display("random: 400 cycles applied");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
